// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback: MEM/WB pipeline register, writeback select and halt sequencer.
// Ports: clk, rst (async, active-high); stall holds the latch, flush bubbles the next entry;
//   in* carry memory-stage results; writeData/writeRegister/regWriteEn drive the register file;
//   dump pulses once when HALT retires, halted is sticky until rst; retired marks a completing
//   instruction; retireCount counts retirements when RETIRE_COUNT_EN is defined, else tied to 0.
module mem_wb_writeback #(
    parameter int DATA_W = 16,
    parameter int REG_W = 3,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              inValid,
    input  logic              inRegWrite,
    input  logic [REG_W-1:0]  inWriteReg,
    input  logic [1:0]        inWbSel,
    input  logic [DATA_W-1:0] inAluResult,
    input  logic [DATA_W-1:0] inMemData,
    input  logic [DATA_W-1:0] inPcPlus2,
    input  logic [DATA_W-1:0] inImm,
    input  logic              inHalt,
    output logic [DATA_W-1:0] writeData,
    output logic [REG_W-1:0]  writeRegister,
    output logic              regWriteEn,
    output logic              dump,
    output logic              halted,
    output logic              retired,
    output logic [CNT_W-1:0]  retireCount
);
    typedef enum logic {RUN, HALTED} state_t;
    state_t state_q, state_d;
    logic valid_q, reg_write_q, halt_q;
    logic [REG_W-1:0] write_reg_q;
    logic [1:0] wb_sel_q;
    logic [DATA_W-1:0] alu_q, mem_q, pc_q, imm_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            halt_q      <= 1'b0;
            write_reg_q <= '0;
            wb_sel_q    <= '0;
            alu_q       <= '0;
            mem_q       <= '0;
            pc_q        <= '0;
            imm_q       <= '0;
        end else if (state_q == HALTED || flush) begin
            valid_q <= 1'b0;
        end else if (!stall) begin
            valid_q     <= inValid;
            reg_write_q <= inRegWrite;
            halt_q      <= inHalt;
            write_reg_q <= inWriteReg;
            wb_sel_q    <= inWbSel;
            alu_q       <= inAluResult;
            mem_q       <= inMemData;
            pc_q        <= inPcPlus2;
            imm_q       <= inImm;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end
    // The resident entry completes only in its first non-stalled cycle, so a held
    // instruction writes exactly once; a retiring HALT dumps instead of writing.
    always_comb begin
        state_d    = state_q;
        retired    = 1'b0;
        dump       = 1'b0;
        regWriteEn = 1'b0;
        halted     = (state_q == HALTED);
        if (state_q == RUN && valid_q && !stall) begin
            retired    = 1'b1;
            dump       = halt_q;
            regWriteEn = reg_write_q & ~halt_q;
            state_d    = halt_q ? HALTED : RUN;
        end
    end
    assign writeData = wb_sel_q[1] ? (wb_sel_q[0] ? imm_q : pc_q)
                                   : (wb_sel_q[0] ? mem_q : alu_q);
    assign writeRegister = write_reg_q;
`ifdef RETIRE_COUNT_EN
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           cnt_q <= '0;
        else if (retired && cnt_q != '1)   cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    assign retireCount = cnt_q;
`else
    assign retireCount = '0;
`endif
endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb_mem_wb_writeback: directed bench with a behavioural writeback model and literal checks.
module tb_mem_wb_writeback;
    typedef struct packed {
        logic        v;
        logic        rw;
        logic [2:0]  rd;
        logic [1:0]  sel;
        logic [15:0] alu;
        logic [15:0] mem;
        logic [15:0] pc;
        logic [15:0] imm;
        logic        h;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall = 1'b0;
    logic flush = 1'b0;
    ent_t in_e = '0;
    logic [15:0] write_data;
    logic [2:0]  write_register;
    logic        reg_write_en, dump, halted, retired;
    logic [15:0] retire_count;
    logic [15:0] wd2;
    logic [2:0]  wr2;
    logic        we2, dump2, halted2, ret2;
    logic [1:0]  retire_count2;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_wb_writeback dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .inValid(in_e.v), .inRegWrite(in_e.rw), .inWriteReg(in_e.rd), .inWbSel(in_e.sel),
        .inAluResult(in_e.alu), .inMemData(in_e.mem), .inPcPlus2(in_e.pc), .inImm(in_e.imm),
        .inHalt(in_e.h),
        .writeData(write_data), .writeRegister(write_register), .regWriteEn(reg_write_en),
        .dump(dump), .halted(halted), .retired(retired), .retireCount(retire_count)
    );

    mem_wb_writeback #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .inValid(in_e.v), .inRegWrite(in_e.rw), .inWriteReg(in_e.rd), .inWbSel(in_e.sel),
        .inAluResult(in_e.alu), .inMemData(in_e.mem), .inPcPlus2(in_e.pc), .inImm(in_e.imm),
        .inHalt(in_e.h),
        .writeData(wd2), .writeRegister(wr2), .regWriteEn(we2),
        .dump(dump2), .halted(halted2), .retired(ret2), .retireCount(retire_count2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the resident instruction, the halted flag and the number of retirements.
    ent_t m;
    logic m_halted;
    int   m_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m        <= '0;
            m_halted <= 1'b0;
            m_cnt    <= 0;
        end else begin
            if (!m_halted && m.v && !stall) begin
                m_cnt <= m_cnt + 1;
                if (m.h) m_halted <= 1'b1;
            end
            if (m_halted || flush) m.v <= 1'b0;
            else if (!stall)       m <= in_e;
        end
    end

    logic [15:0] src [4];
    logic        e_ret, e_we;
    int          e_c16, e_c2;
    always @(negedge clk) begin
        if (!rst) begin
            src   = '{m.alu, m.mem, m.pc, m.imm};
            e_ret = m.v && !m_halted && !stall;
            e_we  = e_ret && m.rw && !m.h;
`ifdef RETIRE_COUNT_EN
            e_c16 = m_cnt > 65535 ? 65535 : m_cnt;
            e_c2  = m_cnt > 3 ? 3 : m_cnt;
`else
            e_c16 = 0;
            e_c2  = 0;
`endif
            chk("retired", retired, e_ret);
            chk("regWriteEn", reg_write_en, e_we);
            chk("dump", dump, e_ret && m.h);
            chk("halted", halted, m_halted);
            chk("retireCount", retire_count, e_c16);
            chk("retireCount_w2", retire_count2, e_c2);
            if (e_we) begin
                chk("writeData", write_data, src[m.sel]);
                chk("writeRegister", write_register, m.rd);
            end
        end
    end

    task automatic vec(input logic v, input logic rw, input logic [2:0] rd, input logic [1:0] sel,
                       input logic [15:0] alu, input logic h, input logic st, input logic fl);
        in_e  = {v, rw, rd, sel, alu, 16'hBEEF, 16'h0042, 16'hFF80, h};
        stall = st;
        flush = fl;
    endtask

    task automatic idle();
        vec(1'b0, 1'b0, 3'd0, 2'd0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic mid_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_regWriteEn", reg_write_en, 0);
        chk("rst_dump", dump, 0);
        chk("rst_halted", halted, 0);
        chk("rst_writeData", write_data, 0);
        chk("rst_retireCount", retire_count, 0);
        idle();
        nxt();
        rst = 1'b0;
    endtask

    logic [15:0] sel_exp [4];

    initial begin
        sel_exp = '{16'h1234, 16'hBEEF, 16'h0042, 16'hFF80};
        #3;
        chk("init_regWriteEn", reg_write_en, 0);
        chk("init_writeData", write_data, 0);
        chk("init_retired", retired, 0);
        nxt();
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            vec(1'b1, 1'b1, 3'd5, s[1:0], 16'h1234, 1'b0, 1'b0, 1'b0);
            nxt();
            idle();
            #1;
            chk("sel_writeData", write_data, sel_exp[s]);
            chk("sel_writeRegister", write_register, 5);
            chk("sel_regWriteEn", reg_write_en, 1);
        end
        vec(1'b1, 1'b1, 3'd3, 2'd0, 16'h00AA, 1'b0, 1'b0, 1'b0);
        nxt();
        vec(1'b0, 1'b0, 3'd0, 2'd0, 16'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_regWriteEn", reg_write_en, 0);
            chk("stall_retired", retired, 0);
            nxt();
        end
        idle();
        #1;
        chk("unstall_regWriteEn", reg_write_en, 1);
        chk("unstall_writeData", write_data, 16'h00AA);
        chk("unstall_writeRegister", write_register, 3);
        chk("unstall_retired", retired, 1);
        nxt();
        #1;
        chk("after_stall_regWriteEn", reg_write_en, 0);
        vec(1'b1, 1'b1, 3'd6, 2'd0, 16'h5555, 1'b0, 1'b1, 1'b1);
        nxt();
        idle();
        #1;
        chk("flush_regWriteEn", reg_write_en, 0);
        chk("flush_retired", retired, 0);
        nxt();
        vec(1'b1, 1'b1, 3'd1, 2'd0, 16'h0011, 1'b0, 1'b0, 1'b0);
        nxt();
        vec(1'b1, 1'b1, 3'd0, 2'd0, 16'h7777, 1'b1, 1'b0, 1'b0);
        #1;
        chk("add_regWriteEn", reg_write_en, 1);
        chk("add_writeRegister", write_register, 1);
        chk("add_writeData", write_data, 16'h0011);
        nxt();
        vec(1'b1, 1'b1, 3'd2, 2'd0, 16'h2222, 1'b0, 1'b0, 1'b0);
        #1;
        chk("halt_dump", dump, 1);
        chk("halt_regWriteEn", reg_write_en, 0);
        chk("halt_retired", retired, 1);
        nxt();
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("halted_regWriteEn", reg_write_en, 0);
            chk("halted_dump", dump, 0);
            chk("halted_flag", halted, 1);
            nxt();
        end
        chk("halted_writeData_held", write_data, 16'h2222);
        mid_reset();
        vec(1'b1, 1'b1, 3'd1, 2'd0, 16'h0001, 1'b0, 1'b0, 1'b0); nxt();
        vec(1'b1, 1'b1, 3'd2, 2'd1, 16'h0002, 1'b0, 1'b0, 1'b0); nxt();
        idle(); nxt();
        vec(1'b1, 1'b0, 3'd3, 2'd2, 16'h0003, 1'b0, 1'b0, 1'b0); nxt();
        vec(1'b1, 1'b1, 3'd4, 2'd3, 16'h0004, 1'b0, 1'b0, 1'b0); nxt();
        idle(); nxt();
        vec(1'b1, 1'b1, 3'd0, 2'd0, 16'h0005, 1'b0, 1'b0, 1'b0); nxt();
        vec(1'b1, 1'b0, 3'd0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0); nxt();
        idle(); nxt();
        #1;
`ifdef RETIRE_COUNT_EN
        chk("count_total", retire_count, 6);
        chk("count_sat_w2", retire_count2, 3);
`else
        chk("count_total", retire_count, 0);
        chk("count_sat_w2", retire_count2, 0);
`endif
        chk("count_halted", halted, 1);
        mid_reset();
        nxt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/mem_wb_writeback.md
Name: mem_wb_writeback

Overview:
- MEM/WB pipeline register plus writeback select. This is the producing end of the register-file write port that the decode stage consumes.
- Latches the memory-stage results and selects the 16-bit write value.
- Drives the write interface (writeData, writeRegister, regWriteEn) back into the decode-stage register file.
- Owns the processor halt sequence: a HALT reaching writeback pulses dump once, then freezes retirement.

Parameters:
- DATA_W, 16, datapath width.
- REG_W, 3, register-select width (8 GPRs).
- CNT_W, 16, retire-counter width (used only with RETIRE_COUNT_EN).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- stall  input  1  hold the latched contents.
- flush  input  1  replace the next latched entry with a bubble.
- inValid  input  1  memory stage holds a real instruction.
- inRegWrite  input  1  instruction writes a GPR.
- inWriteReg  input  REG_W  destination register.
- inWbSel  input  2  write source: 00 ALU, 01 memory, 10 PC+2 (link), 11 immediate.
- inAluResult  input  DATA_W  ALU result.
- inMemData  input  DATA_W  data-memory read value.
- inPcPlus2  input  DATA_W  link address.
- inImm  input  DATA_W  extended immediate.
- inHalt  input  1  instruction is HALT.
- writeData  output  DATA_W  value to the register file.
- writeRegister  output  REG_W  register-file write select.
- regWriteEn  output  1  register-file write enable.
- dump  output  1  one-cycle memory-dump pulse.
- halted  output  1  processor halted, sticky.
- retired  output  1  an instruction completes this cycle.
- retireCount  output  CNT_W  instructions retired (RETIRE_COUNT_EN only; otherwise tied to 0).

Behaviour:
- Reset (async, rst=1): valid=0; all latched fields=0; state=RUN. All outputs 0, including writeData, writeRegister and retireCount.
- Latch update, on the rising clk edge, in priority order:
  - state==HALTED: valid<=0, nothing captured.
  - flush: valid<=0; other fields don't-care, but are held.
  - stall: all fields hold.
  - else: capture every in* field, with valid<=inValid.
- Flush beats stall when both are asserted. Latency: exactly one cycle from capture to write.
- Writeback select is combinational from the latched fields:
  - 00: writeData=ALU.
  - 01: writeData=MEM.
  - 10: writeData=PC+2.
  - 11: writeData=IMM.
- writeRegister = latched destination register.
- regWriteEn = valid & regWrite & ~halt & (state==RUN) & ~stall.
  - During a stall, the held instruction must not write twice. Its write happens in the first non-stalled cycle it is resident.
  - r0 is an ordinary register: writes to r0 are not suppressed.
- retired = valid & (state==RUN) & ~stall. A bubble never retires.
- Halt FSM, two states:
  - RUN: if valid & halt & ~stall, then dump=1 for that cycle, retired=1, no register write, and next state=HALTED.
  - HALTED: halted=1, dump=0, regWriteEn=0, retired=0. Inputs are ignored. The only exit is rst.
- Simultaneous HALT resident and flush asserted: the resident HALT still completes (dump=1). The flush affects only the next latched entry.
- Reset mid-halt, or mid-stall: everything returns to reset values immediately, without waiting for clk.

Optional Feature:
- Macro RETIRE_COUNT_EN.
- Defined:
  - retireCount increments by 1 on each clk edge where retired=1, including the HALT itself.
  - The count saturates at all-ones and does not wrap.
  - Async-cleared by rst.
- Undefined: no counter register exists and retireCount is constant 0.
- All other behaviour is identical either way.

Test Plan:
- Reset: rst=1 asynchronously mid-cycle → regWriteEn=0, dump=0, halted=0, writeData=0 immediately, without a clock edge.
- Select: latch inValid=1, inRegWrite=1, inWriteReg=5, ALU=0x1234, MEM=0xBEEF, PC+2=0x0042, IMM=0xFF80; sweep inWbSel 00/01/10/11 → the next cycle shows writeData=0x1234/0xBEEF/0x0042/0xFF80, writeRegister=5, regWriteEn=1.
- Stall: latch a write to r3=0x00AA, then hold stall=1 for 3 cycles → regWriteEn=0 for those 3 cycles; exactly one regWriteEn=1 pulse on the first cycle after stall drops; retired pulses once.
- Flush vs stall: assert flush=1 and stall=1 together with inValid=1 → next cycle valid=0, regWriteEn=0, retired=0.
- Halt: ADD r1 write, then HALT, then an r2 write → r1 written; HALT cycle has dump=1 for exactly 1 cycle with regWriteEn=0; halted=1 thereafter; the r2 write is never asserted over 10 further cycles.
- RETIRE_COUNT_EN: 5 valid instructions, 2 bubbles, 1 HALT → retireCount=6. With CNT_W=2 and 5 retirements → retireCount saturates at 3.
